// File: rtl/mdl_ctl_axil.sv
// AXI4-Lite control slave: a write to 0x00 fires a one-cycle mode pulse on oCTL_MODE;
// offsets 0x04-0x1C are plain software read/write registers.
module mdl_ctl_axil #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESETN,
   output logic [2:0]                      oCTL_MODE,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY
);
   localparam int NB   = C_S_AXI_DATA_WIDTH / 8;
   localparam int IW   = C_S_AXI_ADDR_WIDTH - 2;
   localparam int NREG = 1 << IW;

   // Handshakes: a beat transfers on a rising edge where valid and ready are both 1;
   // a raised valid holds, payload stable, until that edge.
   logic                          awready_q, awready_d;
   logic                          wready_q, wready_d;
   logic                          aw_en_q, aw_en_d;
   logic [IW-1:0]                 awidx_q, awidx_d;
   logic                          bvalid_q, bvalid_d;
   logic [2:0]                    mode_q, mode_d;
   logic [2:0]                    shadow_q, shadow_d;
   logic                          arready_q, arready_d;
   logic [IW-1:0]                 aridx_q, aridx_d;
   logic                          rvalid_q, rvalid_d;
   logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [C_S_AXI_DATA_WIDTH-1:0] regs_q [NREG];

   logic aw_accept, wren, ctl_hit, ar_accept, rd_fire;
   logic unused_ok;

   assign aw_accept = ~awready_q & S_AXI_AWVALID & S_AXI_WVALID & aw_en_q;
   assign wren      = awready_q & S_AXI_AWVALID & wready_q & S_AXI_WVALID;
   assign ctl_hit   = wren & (awidx_q == '0) & S_AXI_WSTRB[0];
   assign ar_accept = ~arready_q & S_AXI_ARVALID & ~rvalid_q;
   assign rd_fire   = arready_q & S_AXI_ARVALID & ~rvalid_q;
   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // aw_en keeps a single write in flight: closed at acceptance, reopened by the B handshake
   always_comb begin
      awready_d = 1'b0;
      wready_d  = 1'b0;
      aw_en_d   = aw_en_q;
      awidx_d   = awidx_q;
      if (aw_accept) begin
         awready_d = 1'b1;
         wready_d  = 1'b1;
         aw_en_d   = 1'b0;
         awidx_d   = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      end else if (bvalid_q && S_AXI_BREADY) begin
         aw_en_d = 1'b1;
      end
      bvalid_d = bvalid_q;
      if (wren) begin
         bvalid_d = 1'b1;
      end else if (S_AXI_BREADY) begin
         bvalid_d = 1'b0;
      end
      mode_d   = ctl_hit ? S_AXI_WDATA[2:0] : 3'b000;
      shadow_d = ctl_hit ? S_AXI_WDATA[2:0] : shadow_q;
   end

   // Read data is sampled from the pre-edge register state, so a colliding write is not seen
   always_comb begin
      arready_d = ar_accept;
      aridx_d   = ar_accept ? S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2] : aridx_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      if (rd_fire) begin
         rvalid_d = 1'b1;
         rdata_d  = (aridx_q == '0) ? {{(C_S_AXI_DATA_WIDTH-3){1'b0}}, shadow_q}
                                    : regs_q[aridx_q];
      end else if (S_AXI_RREADY) begin
         rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         aw_en_q   <= 1'b1;
         awidx_q   <= '0;
         bvalid_q  <= 1'b0;
         mode_q    <= 3'b000;
         shadow_q  <= 3'b000;
         arready_q <= 1'b0;
         aridx_q   <= '0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         awready_q <= awready_d;
         wready_q  <= wready_d;
         aw_en_q   <= aw_en_d;
         awidx_q   <= awidx_d;
         bvalid_q  <= bvalid_d;
         mode_q    <= mode_d;
         shadow_q  <= shadow_d;
         arready_q <= arready_d;
         aridx_q   <= aridx_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
      end
   end

   // Entry 0 of the array is never written; index 0 reads come from the mode shadow
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else if (wren && (awidx_q != '0)) begin
         for (int b = 0; b < NB; b++) begin
            if (S_AXI_WSTRB[b]) regs_q[awidx_q][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
         end
      end
   end

   assign oCTL_MODE     = mode_q;
   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = 2'b00;
   assign S_AXI_RVALID  = rvalid_q;

endmodule

// File: tb/tb_mdl_ctl_axil.sv
// Directed bench for mdl_ctl_axil: mode pulse timing, B backpressure, scratch registers,
// byte strobes, read/write collision and asynchronous reset.
module tb_mdl_ctl_axil;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  octl;
   logic [4:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;

   int vectors     = 0;
   int miscompares = 0;
   int pulse_cnt   = 0;

   mdl_ctl_axil dut (
      .S_AXI_ACLK(clk),       .S_AXI_ARESETN(rst_n),  .oCTL_MODE(octl),
      .S_AXI_AWADDR(awaddr),  .S_AXI_AWPROT(awprot),  .S_AXI_AWVALID(awvalid),
      .S_AXI_AWREADY(awready), .S_AXI_WDATA(wdata),   .S_AXI_WSTRB(wstrb),
      .S_AXI_WVALID(wvalid),  .S_AXI_WREADY(wready),  .S_AXI_BRESP(bresp),
      .S_AXI_BVALID(bvalid),  .S_AXI_BREADY(bready),  .S_AXI_ARADDR(araddr),
      .S_AXI_ARPROT(arprot),  .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata),    .S_AXI_RRESP(rresp),    .S_AXI_RVALID(rvalid),
      .S_AXI_RREADY(rready)
   );

   // clock / reset
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst_n && octl !== 3'b000) pulse_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      awaddr = '0; araddr = '0; awprot = 3'b000; arprot = 3'b000;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      bready = 1'b0; rready = 1'b0; wdata = '0; wstrb = '0;
   endtask

   // driver tasks: report completion through ok, never compare
   task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output bit ok, output logic [2:0] mode);
      int n;
      ok = 1'b0; mode = 3'b000;
      awaddr = addr; wdata = data; wstrb = strb;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      n = 0;
      while (awready !== 1'b1 && n < 20) begin tick(); n++; end
      if (awready === 1'b1) begin
         tick();
         awvalid = 1'b0; wvalid = 1'b0;
         n = 0;
         while (bvalid !== 1'b1 && n < 20) begin tick(); n++; end
         if (bvalid === 1'b1) begin
            mode = octl; ok = (bresp === 2'b00);
            tick();
         end
      end
      awvalid = 1'b0; wvalid = 1'b0;
   endtask

   task automatic axi_read(input logic [4:0] addr, output bit ok, output logic [31:0] data);
      int n;
      ok = 1'b0; data = 'x;
      araddr = addr; arvalid = 1'b1; rready = 1'b1;
      n = 0;
      while (arready !== 1'b1 && n < 20) begin tick(); n++; end
      if (arready === 1'b1) begin
         tick();
         arvalid = 1'b0;
         n = 0;
         while (rvalid !== 1'b1 && n < 20) begin tick(); n++; end
         if (rvalid === 1'b1) begin
            data = rdata; ok = (rresp === 2'b00);
            tick();
         end
      end
      arvalid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      #100;
      rst_n = 1'b1;
      repeat (5) tick();
      vectors++; if (awready !== 1'b0) begin miscompares++; $display("FAIL rst_awready: got %b want 0", awready); end
      vectors++; if (wready !== 1'b0) begin miscompares++; $display("FAIL rst_wready: got %b want 0", wready); end
      vectors++; if (bvalid !== 1'b0) begin miscompares++; $display("FAIL rst_bvalid: got %b want 0", bvalid); end
      vectors++; if (arready !== 1'b0) begin miscompares++; $display("FAIL rst_arready: got %b want 0", arready); end
      vectors++; if (rvalid !== 1'b0) begin miscompares++; $display("FAIL rst_rvalid: got %b want 0", rvalid); end
      vectors++; if (octl !== 3'b000) begin miscompares++; $display("FAIL rst_mode: got %b want 000", octl); end
      vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata: got %h want 0", rdata); end
   endtask

   task automatic test_ctl_pulse();
      awaddr = 5'h00; wdata = 32'h7; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      tick();
      vectors++; if ({awready, wready} !== 2'b11) begin miscompares++; $display("FAIL pulse_accept: got %b want 11", {awready, wready}); end
      vectors++; if (octl !== 3'b000) begin miscompares++; $display("FAIL pulse_early: got %b want 000", octl); end
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      vectors++; if ({awready, wready} !== 2'b00) begin miscompares++; $display("FAIL pulse_ready_drop: got %b want 00", {awready, wready}); end
      vectors++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin miscompares++; $display("FAIL pulse_b: got %b/%b want 1/00", bvalid, bresp); end
      vectors++; if (octl !== 3'b111) begin miscompares++; $display("FAIL pulse_mode: got %b want 111", octl); end
      tick();
      vectors++; if (octl !== 3'b000 || bvalid !== 1'b0) begin miscompares++; $display("FAIL pulse_end: got mode %b bvalid %b want 000/0", octl, bvalid); end
   endtask

   task automatic test_ctl_backpressure();
      int p0;
      p0 = pulse_cnt;
      awaddr = 5'h00; wdata = 32'h5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      tick();
      tick();
      vectors++; if (octl !== 3'b101 || bvalid !== 1'b1) begin miscompares++; $display("FAIL bp_pulse: got mode %b bvalid %b want 101/1", octl, bvalid); end
      awaddr = 5'h08; wdata = 32'h1234_5678;
      tick();
      vectors++; if (octl !== 3'b000) begin miscompares++; $display("FAIL bp_mode_once: got %b want 000", octl); end
      vectors++; if (bvalid !== 1'b1 || awready !== 1'b0) begin miscompares++; $display("FAIL bp_hold2: got bvalid %b awready %b want 1/0", bvalid, awready); end
      tick();
      vectors++; if (bvalid !== 1'b1 || awready !== 1'b0) begin miscompares++; $display("FAIL bp_hold3: got bvalid %b awready %b want 1/0", bvalid, awready); end
      bready = 1'b1;
      tick();
      vectors++; if (bvalid !== 1'b0 || awready !== 1'b0) begin miscompares++; $display("FAIL bp_release: got bvalid %b awready %b want 0/0", bvalid, awready); end
      tick();
      vectors++; if (awready !== 1'b1) begin miscompares++; $display("FAIL bp_second_accept: got %b want 1", awready); end
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      vectors++; if (bvalid !== 1'b1 || octl !== 3'b000) begin miscompares++; $display("FAIL bp_second_b: got bvalid %b mode %b want 1/000", bvalid, octl); end
      tick();
      vectors++; if (pulse_cnt - p0 !== 1) begin miscompares++; $display("FAIL bp_pulse_count: got %0d want 1", pulse_cnt - p0); end
   endtask

   task automatic test_gp_rw();
      bit ok; logic [2:0] m; logic [31:0] d; int p0;
      p0 = pulse_cnt;
      axi_write(5'h08, 32'hDEAD_BEEF, 4'hF, ok, m);
      vectors++; if (ok !== 1'b1 || m !== 3'b000) begin miscompares++; $display("FAIL gp_wr08: got ok %b mode %b want 1/000", ok, m); end
      axi_read(5'h08, ok, d);
      vectors++; if (ok !== 1'b1 || d !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL gp_rd08: got ok %b data %h want 1/deadbeef", ok, d); end
      axi_read(5'h0B, ok, d);
      vectors++; if (ok !== 1'b1 || d !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL gp_rd0b: got ok %b data %h want 1/deadbeef", ok, d); end
      axi_read(5'h00, ok, d);
      vectors++; if (ok !== 1'b1 || d !== 32'h5) begin miscompares++; $display("FAIL gp_rd00: got ok %b data %h want 1/00000005", ok, d); end
      axi_write(5'h1C, 32'hA5A5_5A5A, 4'hF, ok, m);
      axi_read(5'h1C, ok, d);
      vectors++; if (ok !== 1'b1 || d !== 32'hA5A5_5A5A) begin miscompares++; $display("FAIL gp_rd1c: got ok %b data %h want 1/a5a55a5a", ok, d); end
      vectors++; if (pulse_cnt - p0 !== 0) begin miscompares++; $display("FAIL gp_no_pulse: got %0d want 0", pulse_cnt - p0); end
   endtask

   task automatic test_strobes();
      bit ok; logic [2:0] m; logic [31:0] d; int p0;
      p0 = pulse_cnt;
      axi_write(5'h00, 32'h2, 4'h0, ok, m);
      vectors++; if (ok !== 1'b1 || m !== 3'b000) begin miscompares++; $display("FAIL strb0_ctl: got ok %b mode %b want 1/000", ok, m); end
      axi_read(5'h00, ok, d);
      vectors++; if (d !== 32'h5) begin miscompares++; $display("FAIL strb0_shadow: got %h want 00000005", d); end
      vectors++; if (pulse_cnt - p0 !== 0) begin miscompares++; $display("FAIL strb0_no_pulse: got %0d want 0", pulse_cnt - p0); end
      axi_write(5'h04, 32'h0000_00FF, 4'h1, ok, m);
      axi_read(5'h04, ok, d);
      vectors++; if (d !== 32'h0000_00FF) begin miscompares++; $display("FAIL strb_b0: got %h want 000000ff", d); end
      axi_write(5'h04, 32'h12AB_3456, 4'h4, ok, m);
      axi_read(5'h04, ok, d);
      vectors++; if (d !== 32'h00AB_00FF) begin miscompares++; $display("FAIL strb_b2: got %h want 00ab00ff", d); end
      axi_write(5'h00, 32'hFFFF_FFF9, 4'h1, ok, m);
      vectors++; if (m !== 3'b001) begin miscompares++; $display("FAIL ctl_low3: got %b want 001", m); end
      axi_read(5'h00, ok, d);
      vectors++; if (d !== 32'h1) begin miscompares++; $display("FAIL ctl_shadow: got %h want 00000001", d); end
   endtask

   task automatic test_collision();
      bit ok; logic [2:0] m; logic [31:0] d;
      axi_write(5'h0C, 32'h1111_1111, 4'hF, ok, m);
      awaddr = 5'h0C; wdata = 32'h2222_2222; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      araddr = 5'h0C; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
      tick();
      vectors++; if ({awready, arready} !== 2'b11) begin miscompares++; $display("FAIL coll_accept: got %b want 11", {awready, arready}); end
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      vectors++; if ({bvalid, rvalid} !== 2'b11) begin miscompares++; $display("FAIL coll_valid: got %b want 11", {bvalid, rvalid}); end
      vectors++; if (rdata !== 32'h1111_1111) begin miscompares++; $display("FAIL coll_old: got %h want 11111111", rdata); end
      tick();
      axi_read(5'h0C, ok, d);
      vectors++; if (d !== 32'h2222_2222) begin miscompares++; $display("FAIL coll_new: got %h want 22222222", d); end
   endtask

   task automatic test_reset_mid();
      bit ok; logic [31:0] d; int p0;
      awaddr = 5'h00; wdata = 32'h6; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      tick();
      tick();
      vectors++; if (octl !== 3'b110 || bvalid !== 1'b1) begin miscompares++; $display("FAIL rm_pre: got mode %b bvalid %b want 110/1", octl, bvalid); end
      rst_n = 1'b0;
      idle_inputs();
      #1;
      vectors++; if (bvalid !== 1'b0 || octl !== 3'b000) begin miscompares++; $display("FAIL rm_async: got bvalid %b mode %b want 0/000", bvalid, octl); end
      tick();
      rst_n = 1'b1;
      tick();
      axi_read(5'h1C, ok, d);
      vectors++; if (ok !== 1'b1 || d !== 32'h0) begin miscompares++; $display("FAIL rm_reg1c: got ok %b data %h want 1/0", ok, d); end
      axi_read(5'h00, ok, d);
      vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL rm_shadow: got %h want 0", d); end
      p0 = pulse_cnt;
      awaddr = 5'h00; wdata = 32'h4; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      tick();
      rst_n = 1'b0;
      idle_inputs();
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      vectors++; if (pulse_cnt - p0 !== 0 || bvalid !== 1'b0) begin miscompares++; $display("FAIL rm_abort: got pulses %0d bvalid %b want 0/0", pulse_cnt - p0, bvalid); end
   endtask

   initial begin
      test_reset();
      test_ctl_pulse();
      test_ctl_backpressure();
      test_gp_rw();
      test_strobes();
      test_collision();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mdl_ctl_axil.md
Name: mdl_ctl_axil

Overview:
- AXI4-Lite slave control block that lets the processor start hardware operations in the HW/SW co-design.
- A write to the control register at offset 0x00 emits a one-cycle start/mode pulse on oCTL_MODE, which drives the accelerator datapath.
- Offsets 0x04–0x1C are general-purpose software read/write registers.

Parameters:
- C_S_AXI_DATA_WIDTH, 32: AXI data width (only 32 supported).
- C_S_AXI_ADDR_WIDTH, 5: AXI byte-address width; 8 word registers.

Ports:
- S_AXI_ACLK  in  1  single clock; all logic on rising edge.
- S_AXI_ARESETN  in  1  reset, asynchronous, active-low.
- oCTL_MODE  out  3  one-cycle mode/start pulse; 000 = idle.
- S_AXI_AWADDR  in  5  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte strobes.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BRESP  out  2  always 00 (OKAY).
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_ARADDR  in  5  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 00 (OKAY).
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data ready.

Behaviour:
- Reset (ARESETN=0, asynchronous): all ready/valid outputs 0; RDATA=0; oCTL_MODE=000; all registers 0; aw_en=1. Reset mid-transaction aborts it with no pulse and no response.
- Write address/data acceptance:
  - AWREADY pulses high for exactly one cycle when AWVALID, WVALID and aw_en are all 1 and AWREADY is 0.
  - WREADY pulses under the same condition, in the same cycle.
  - aw_en clears at acceptance and sets again when the B handshake completes (BVALID & BREADY), so only one write is outstanding at a time.
  - AW without W, or W without AW, waits; nothing is accepted.
- Write enable: wren = AWREADY & AWVALID & WREADY & WVALID. Register index = AWADDR[4:2] latched at acceptance; AWADDR[1:0] is ignored.
- Write response: BVALID rises the cycle after wren and holds until BREADY=1. If BREADY is already 1, BVALID lasts exactly one cycle.
- Control register, index 0:
  - On wren with index 0 and WSTRB[0]=1, the next cycle oCTL_MODE = WDATA[2:0], for exactly one cycle. This is the same cycle BVALID first rises.
  - In every other cycle oCTL_MODE = 000. The pulse is independent of BREADY.
  - A shadow copy of WDATA[2:0] is stored for readback.
  - With WSTRB[0]=0 there is no pulse and no update.
- Registers 1–7: 32-bit read/write, byte-enabled by WSTRB.
- Read channel:
  - ARREADY pulses for one cycle when ARVALID=1, ARREADY=0 and RVALID=0. The read address is latched at that point.
  - RVALID rises the next cycle with registered RDATA and holds until RREADY.
  - Index 0 returns {29'b0, shadow[2:0]}; indices 1–7 return their contents.
- Simultaneous read and write: the channels are independent and both are served. On a same-cycle collision, a read returns the pre-write value.

Test Plan:
- Reset 100 ns, release, idle 5 cycles -> all valid/ready 0, oCTL_MODE=000.
- AWADDR=0, WDATA=7, WSTRB=F, AWVALID=WVALID=1 for 2 cycles, BREADY=1 -> AWREADY/WREADY one-cycle pulse; next cycle BVALID=1, BRESP=00, oCTL_MODE=111; following cycle oCTL_MODE=000, BVALID=0.
- Write WDATA=5 to 0x00 with BREADY=0 for 3 cycles -> oCTL_MODE=101 for exactly one cycle; BVALID held 3 cycles; no second write accepted until B handshake.
- Write 0xDEADBEEF to 0x08, then read 0x08 -> RDATA=0xDEADBEEF, RRESP=00, oCTL_MODE stays 000; read 0x00 -> RDATA=5.
- Write 0x00 with WSTRB=0 -> BVALID returned, no pulse; write 0x04 with WSTRB=0001 data 0xFF -> reads 0x000000FF.
- Assert reset while BVALID=1 -> BVALID, oCTL_MODE, registers immediately 0.
